// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cla_adder
// Description : Two-stage pipelined carry-lookahead adder/subtractor with
//               valid/ready flow control, signed overflow and word-level
//               propagate/generate outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             word_p,
  output logic             word_g
);

  localparam int NGRP = WIDTH / GROUP;

  // Flow control
  logic w_s1_adv;
  logic w_s2_adv;

  // Stage 1 combinational terms
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_c0;
  logic [NGRP-1:0]  w_gp;
  logic [NGRP-1:0]  w_gg;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic [NGRP-1:0]  r_gp;
  logic [NGRP-1:0]  r_gg;
  logic             r_c0;

  // Stage 2 combinational terms
  logic [NGRP:0]    w_gc;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_word_g;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_word_p;
  logic             r_word_g;

  // A stage may load when it is empty or its contents move on this edge;
  // this makes in_ready combinationally dependent on out_ready.
  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Subtraction is a + ~b + 1, so the carry-in is forced high and cin ignored.
  assign w_bx = b ^ {WIDTH{sub}};
  assign w_c0 = sub | cin;
  assign w_p  = a ^ w_bx;
  assign w_g  = a & w_bx;

  // Group propagate/generate via in-group lookahead (generate independent of carry-in)
  always_comb begin
    logic w_acc;
    w_gp = '0;
    w_gg = '0;
    for (int k = 0; k < NGRP; k++) begin
      w_gp[k] = &w_p[k*GROUP +: GROUP];
      w_acc   = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        w_acc = w_g[k*GROUP+i] | (w_p[k*GROUP+i] & w_acc);
      end
      w_gg[k] = w_acc;
    end
  end

  // Stage 1 register: captures bit and group P/G plus carry-in on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_gp       <= '0;
      r_gg       <= '0;
      r_c0       <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid && w_s1_adv;
      r_p        <= w_p;
      r_g        <= w_g;
      r_gp       <= w_gp;
      r_gg       <= w_gg;
      r_c0       <= w_c0;
    end
  end

  // Group carry-ins from group lookahead, then ripple inside each group
  always_comb begin
    w_gc    = '0;
    w_c     = '0;
    w_gc[0] = r_c0;
    for (int k = 0; k < NGRP; k++) begin
      w_gc[k+1] = r_gg[k] | (r_gp[k] & w_gc[k]);
    end
    for (int k = 0; k < NGRP; k++) begin
      w_c[k*GROUP] = w_gc[k];
      for (int i = 0; i < GROUP - 1; i++) begin
        w_c[k*GROUP+i+1] = r_g[k*GROUP+i] | (r_p[k*GROUP+i] & w_c[k*GROUP+i]);
      end
    end
    w_c[WIDTH] = w_gc[NGRP];
  end

  assign w_sum = r_p ^ w_c[WIDTH-1:0];

  // Word generate folds the group P/G from LSB group up, with zero carry-in
  always_comb begin
    w_word_g = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      w_word_g = r_gg[k] | (r_gp[k] & w_word_g);
    end
  end

  // Stage 2 register: result held stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_word_p    <= 1'b0;
      r_word_g    <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      r_sum       <= w_sum;
      r_cout      <= w_c[WIDTH];
      r_ovf       <= w_c[WIDTH-1] ^ w_c[WIDTH];
      r_word_p    <= &r_gp;
      r_word_g    <= w_word_g;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign word_p    = r_word_p;
  assign word_g    = r_word_g;

endmodule
`default_nettype wire
